// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits WAIT_CYCLES, then answers.
// Optional fault checking (misaligned / out-of-range addresses) under `DMEM_ERR_CHECK_EN.
module dmem_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  dbg_state
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // a response transfers on a rising edge where rsp_valid && rsp_ready. Once
    // rsp_valid rises, rsp_rdata/rsp_err hold until that transfer.

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        write_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    logic [31:0] mem [DEPTH];

    logic        accept;
    logic        do_access;
    logic        fault;
    logic        mem_we;
    logic        acc_write;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_wstrb;
    logic [AW-1:0] acc_idx;

    assign accept = req_valid && req_ready;

    // With zero wait states the access happens on the accept edge, so the
    // access operands come straight from the request inputs while idle.
    assign acc_write = (state_q == S_IDLE) ? req_write : write_q;
    assign acc_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
    assign acc_wstrb = (state_q == S_IDLE) ? req_wstrb : wstrb_q;

`ifdef DMEM_ERR_CHECK_EN
    logic [31:0] addr_q;
    logic [31:0] acc_addr;

    assign acc_addr = (state_q == S_IDLE) ? req_addr : addr_q;
    assign acc_idx  = acc_addr[AW+1:2];
    assign fault    = (acc_addr[1:0] != 2'b00) || (acc_addr >= 32'(4 * DEPTH));

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q <= '0;
        end else if (accept) begin
            addr_q <= req_addr;
        end
    end
`else
    logic [AW-1:0] idx_q;
    logic          unused_addr_bits;

    // Byte offset and bits above the array are deliberately dropped: addresses wrap.
    assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};
    assign acc_idx          = (state_q == S_IDLE) ? req_addr[AW+1:2] : idx_q;
    assign fault            = 1'b0;

    always_ff @(posedge clock) begin
        if (reset) begin
            idx_q <= '0;
        end else if (accept) begin
            idx_q <= req_addr[AW+1:2];
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        do_access = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d   = S_RESP;
                        do_access = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d   = S_RESP;
                    cnt_d     = 4'd0;
                    do_access = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        if (do_access) begin
            err_d = fault;
            if (acc_write || fault) begin
                rdata_d = 32'd0;
            end else begin
                rdata_d = mem[acc_idx];
            end
            mem_we = acc_write && !fault;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            write_q <= 1'b0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
        end else if (accept) begin
            write_q <= req_write;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
        end
    end

    // Array contents are not reset; a reset on the commit edge suppresses the write.
    always_ff @(posedge clock) begin
        if (!reset && mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_wstrb[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = (state_q == S_IDLE) && !reset;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states, one with none.
module tb_dmem_responder;

    localparam int W_A = 2;
    localparam int W_B = 0;

    logic        clock;
    logic        reset_s     [2];
    logic        req_valid_s [2];
    logic        req_ready_s [2];
    logic        req_write_s [2];
    logic [31:0] req_addr_s  [2];
    logic [31:0] req_wdata_s [2];
    logic [3:0]  req_wstrb_s [2];
    logic        rsp_valid_s [2];
    logic        rsp_ready_s [2];
    logic [31:0] rsp_rdata_s [2];
    logic        rsp_err_s   [2];
    logic [1:0]  dbg_state_s [2];

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          sel;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    // ---------------- clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    dmem_responder #(.DEPTH(64), .WAIT_CYCLES(W_A)) u_w2 (
        .clock     (clock),
        .reset     (reset_s[0]),
        .req_valid (req_valid_s[0]),
        .req_ready (req_ready_s[0]),
        .req_write (req_write_s[0]),
        .req_addr  (req_addr_s[0]),
        .req_wdata (req_wdata_s[0]),
        .req_wstrb (req_wstrb_s[0]),
        .rsp_valid (rsp_valid_s[0]),
        .rsp_ready (rsp_ready_s[0]),
        .rsp_rdata (rsp_rdata_s[0]),
        .rsp_err   (rsp_err_s[0]),
        .dbg_state (dbg_state_s[0])
    );

    dmem_responder #(.DEPTH(64), .WAIT_CYCLES(W_B)) u_w0 (
        .clock     (clock),
        .reset     (reset_s[1]),
        .req_valid (req_valid_s[1]),
        .req_ready (req_ready_s[1]),
        .req_write (req_write_s[1]),
        .req_addr  (req_addr_s[1]),
        .req_wdata (req_wdata_s[1]),
        .req_wstrb (req_wstrb_s[1]),
        .rsp_valid (rsp_valid_s[1]),
        .rsp_ready (rsp_ready_s[1]),
        .rsp_rdata (rsp_rdata_s[1]),
        .rsp_err   (rsp_err_s[1]),
        .dbg_state (dbg_state_s[1])
    );

    // ---------------- checking
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver
    task automatic txn(input int sel, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       output logic [31:0] rdata, output logic err, output int lat);
        int guard;
        @(negedge clock);
        req_valid_s[sel] = 1'b1;
        req_write_s[sel] = wr;
        req_addr_s[sel]  = addr;
        req_wdata_s[sel] = wdata;
        req_wstrb_s[sel] = strb;
        guard = 0;
        while (req_ready_s[sel] !== 1'b1 && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 50) begin
            total++;
            bad++;
            $display("FAIL req_ready_timeout: got 0 expected 1 within 50 cycles");
        end
        @(posedge clock);
        #1 req_valid_s[sel] = 1'b0;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (rsp_valid_s[sel] !== 1'b1 && lat < 50);
        rdata = rsp_rdata_s[sel];
        err   = rsp_err_s[sel];
        rsp_ready_s[sel] = 1'b1;
        @(posedge clock);
        #1 rsp_ready_s[sel] = 1'b0;
    endtask

    task automatic add(input int sel, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.sel = sel; v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        vecs.push_back(v);
    endtask

    // ---------------- stimulus
    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          guard;

        for (int s = 0; s < 2; s++) begin
            reset_s[s]     = 1'b1;
            req_valid_s[s] = 1'b0;
            req_write_s[s] = 1'b0;
            req_addr_s[s]  = 32'd0;
            req_wdata_s[s] = 32'd0;
            req_wstrb_s[s] = 4'd0;
            rsp_ready_s[s] = 1'b0;
        end

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("ready_in_reset_a", {31'd0, req_ready_s[0]}, 32'd0);
        check("ready_in_reset_b", {31'd0, req_ready_s[1]}, 32'd0);
        reset_s[0] = 1'b0;
        reset_s[1] = 1'b0;
        @(negedge clock);
        check("ready_after_reset", {31'd0, req_ready_s[0]}, 32'd1);
        check("valid_after_reset", {31'd0, rsp_valid_s[0]}, 32'd0);
        check("rdata_after_reset", rsp_rdata_s[0], 32'd0);
        check("err_after_reset", {31'd0, rsp_err_s[0]}, 32'd0);
        check("state_after_reset", {30'd0, dbg_state_s[0]}, 32'd0);

        // Vector table
        add(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0,        1'b0);
        add(0, 1'b0, 32'h10, 32'h0,        4'b0000, 32'hDEADBEEF, 1'b0);
        add(0, 1'b1, 32'h20, 32'h11223344, 4'b1111, 32'h0,        1'b0);
        add(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0,        1'b0);
        add(0, 1'b0, 32'h20, 32'h0,        4'b0000, 32'h11BB33DD, 1'b0);
        add(0, 1'b1, 32'h10, 32'h12345678, 4'b0000, 32'h0,        1'b0);
        add(0, 1'b0, 32'h10, 32'h0,        4'b0000, 32'hDEADBEEF, 1'b0);
        add(0, 1'b1, 32'h24, 32'hFFFFFFFF, 4'b1111, 32'h0,        1'b0);
        add(0, 1'b1, 32'h24, 32'h00000000, 4'b1010, 32'h0,        1'b0);
        add(0, 1'b0, 32'h24, 32'h0,        4'b0000, 32'h00FF00FF, 1'b0);
`ifdef DMEM_ERR_CHECK_EN
        add(0, 1'b1, 32'h0,   32'h77777777, 4'b1111, 32'h0,        1'b0);
        add(0, 1'b0, 32'h102, 32'h0,        4'b0000, 32'h0,        1'b1);
        add(0, 1'b1, 32'h100, 32'h12345678, 4'b1111, 32'h0,        1'b1);
        add(0, 1'b0, 32'h0,   32'h0,        4'b0000, 32'h77777777, 1'b0);
`else
        add(0, 1'b1, 32'h100, 32'h00000055, 4'b1111, 32'h0,        1'b0);
        add(0, 1'b0, 32'h0,   32'h0,        4'b0000, 32'h00000055, 1'b0);
        add(0, 1'b0, 32'h3,   32'h0,        4'b0000, 32'h00000055, 1'b0);
`endif
        add(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0,        1'b0);
        add(1, 1'b0, 32'h10, 32'h0,        4'b0000, 32'hDEADBEEF, 1'b0);

        foreach (vecs[i]) begin
            txn(vecs[i].sel, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd, er, lat);
            check($sformatf("rdata[%0d]", i), rd, vecs[i].exp_rdata);
            check($sformatf("err[%0d]", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
            check($sformatf("latency[%0d]", i), 32'(lat),
                  32'(1 + ((vecs[i].sel == 0) ? W_A : W_B)));
        end

        // Backpressure: response held 5 cycles, second request ignored meanwhile
        @(negedge clock);
        req_valid_s[0] = 1'b1;
        req_write_s[0] = 1'b0;
        req_addr_s[0]  = 32'h10;
        @(posedge clock);
        #1 req_valid_s[0] = 1'b0;
        guard = 0;
        do begin
            @(negedge clock);
            guard++;
        end while (rsp_valid_s[0] !== 1'b1 && guard < 50);
        check("bp_latency", 32'(guard), 32'(1 + W_A));
        req_valid_s[0] = 1'b1;
        req_write_s[0] = 1'b1;
        req_addr_s[0]  = 32'h10;
        req_wdata_s[0] = 32'h0BADBAD0;
        req_wstrb_s[0] = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_valid[%0d]", k), {31'd0, rsp_valid_s[0]}, 32'd1);
            check($sformatf("bp_rdata[%0d]", k), rsp_rdata_s[0], 32'hDEADBEEF);
            check($sformatf("bp_ready[%0d]", k), {31'd0, req_ready_s[0]}, 32'd0);
            @(negedge clock);
        end
        rsp_ready_s[0] = 1'b1;
        @(posedge clock);
        #1;
        rsp_ready_s[0] = 1'b0;
        req_valid_s[0] = 1'b0;
        @(negedge clock);
        check("bp_idle_valid", {31'd0, rsp_valid_s[0]}, 32'd0);
        check("bp_idle_ready", {31'd0, req_ready_s[0]}, 32'd1);
        txn(0, 1'b0, 32'h10, 32'h0, 4'b0000, rd, er, lat);
        check("bp_store_ignored", rd, 32'hDEADBEEF);

        // Reset in WAIT aborts the store
        txn(0, 1'b1, 32'h30, 32'h0, 4'b1111, rd, er, lat);
        @(negedge clock);
        req_valid_s[0] = 1'b1;
        req_write_s[0] = 1'b1;
        req_addr_s[0]  = 32'h30;
        req_wdata_s[0] = 32'hCAFEF00D;
        req_wstrb_s[0] = 4'b1111;
        @(posedge clock);
        #1;
        req_valid_s[0] = 1'b0;
        check("abort_in_wait", {30'd0, dbg_state_s[0]}, 32'd1);
        reset_s[0] = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_s[0] = 1'b0;
        @(negedge clock);
        check("abort_ready", {31'd0, req_ready_s[0]}, 32'd1);
        check("abort_valid", {31'd0, rsp_valid_s[0]}, 32'd0);
        txn(0, 1'b0, 32'h30, 32'h0, 4'b0000, rd, er, lat);
        check("abort_no_write", rd, 32'h0);

        // Back-to-back loads, zero wait states, rsp_ready held high
        @(negedge clock);
        req_valid_s[1] = 1'b1;
        req_write_s[1] = 1'b0;
        req_addr_s[1]  = 32'h10;
        rsp_ready_s[1] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            check($sformatf("b2b_valid[%0d]", k), {31'd0, rsp_valid_s[1]},
                  (k % 2 == 0) ? 32'd1 : 32'd0);
            if (k % 2 == 0) begin
                check($sformatf("b2b_rdata[%0d]", k), rsp_rdata_s[1], 32'hDEADBEEF);
            end
        end
        req_valid_s[1] = 1'b0;
        rsp_ready_s[1] = 1'b0;
        repeat (2) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder: the memory-side end of the processor's load/store request/response handshake. Accepts one request at a time from the core, inserts a configurable number of wait states, performs a byte-masked word write or a word read on an internal array, and returns a response through a valid/ready handshake. Used as the core's data memory in system simulation and to stress the core's stall handling.

## Interface
Parameters:
- DEPTH, 64: number of 32-bit words; power of two, 4..1024.
- WAIT_CYCLES, 2: wait states between request acceptance and response; 0..15.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  core presents a request.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_wstrb  in  4  byte enables; bit i enables byte lane i (bits [8i+7:8i]).
- rsp_valid  out  1  response available.
- rsp_ready  in  1  core accepts the response.
- rsp_rdata  out  32  load data; 0 for stores.
- rsp_err  out  1  request faulted (see Configuration).

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid && req_ready, latch write, addr, wdata, wstrb; load wait counter with WAIT_CYCLES; go to WAIT, or straight to RESP if WAIT_CYCLES=0.
- WAIT: req_ready=0; counter decrements each cycle; when the counter reaches 1, the next edge performs the access and enters RESP.
- Access (on the edge entering RESP): word index = addr[log2(DEPTH)+1:2]. Store: only lanes with wstrb=1 updated; rdata register cleared to 0. Load: rdata register loaded with the full word. Store with wstrb=0000 is legal, modifies nothing, responds normally.
- RESP: rsp_valid=1, rsp_rdata/rsp_err held stable until rsp_ready=1; on that edge go to IDLE.
- Request inputs are ignored outside IDLE; no pipelining, at most one outstanding request.
- Memory array is not cleared by reset; contents survive reset.

## Timing
- Reset values: req_ready=0 during reset, 1 on the first cycle after reset deasserts; rsp_valid=0, rsp_rdata=0, rsp_err=0; state=IDLE, counter=0.
- Request accepted at edge N -> rsp_valid high from cycle N+1+WAIT_CYCLES.
- Response accepted at edge M -> req_ready high in cycle M+1; minimum request-to-request spacing WAIT_CYCLES+2 cycles.
- rsp_ready high before rsp_valid has no effect; rsp_ready held high gives a one-cycle RESP.
- Reset asserted in WAIT: request aborted, no memory write. Reset asserted in RESP: response dropped; store already committed stays committed.
- Store followed by load to the same address returns the stored data (commit precedes the load's acceptance).

## Configuration
- DMEM_ERR_CHECK_EN defined: request faults if addr[1:0]!=0 or addr >= 4*DEPTH; faulting request takes the normal latency, performs no write, returns rsp_rdata=0 and rsp_err=1.
- Undefined: rsp_err tied 0; addr[1:0] ignored; upper address bits ignored so accesses wrap modulo DEPTH words.

## Test plan
- Reset then store 0xDEADBEEF, wstrb=1111, addr 0x10, then load 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0; rsp_valid first high exactly 1+WAIT_CYCLES cycles after each accept (WAIT_CYCLES=2 and 0).
- Store 0x11223344 wstrb 1111 to 0x20, then store 0xAABBCCDD wstrb 0101, load 0x20 -> 0x11BB33DD.
- Backpressure: hold rsp_ready=0 for 5 cycles during a load -> rsp_valid and rsp_rdata stable all 5 cycles, req_ready=0, second req_valid ignored until handshake.
- With DMEM_ERR_CHECK_EN, DEPTH=64: load 0x102 -> rsp_err=1, rdata=0; store to 0x100 -> rsp_err=1, word 0 unchanged. Without macro: store 0x55 to 0x100 then load 0x0 -> 0x55, rsp_err=0.
- Reset asserted during WAIT of a store 0xCAFEF00D to 0x30 (previously 0) -> after reset req_ready=1, rsp_valid=0, load 0x30 returns 0.
- Back-to-back loads with rsp_ready held high, WAIT_CYCLES=0 -> one response every 2 cycles.
